// File: rtl/fifo_write_arbiter.sv
// Round-robin write-port arbiter for top_FIFO: grants one producer per burst
// and tracks FIFO occupancy from issued writes and observed reads.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                            Clock,
  input  logic                            Reset,
  input  logic                            Enable,
  input  logic [NUM_REQ-1:0]              Req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   Req_Data,
  output logic [NUM_REQ-1:0]              Grant,
  input  logic                            RE_Mon,
  output logic                            WE,
  output logic [DATA_WIDTH-1:0]           Write_Data,
  output logic [$clog2(DEPTH+1)-1:0]      Count,
  output logic                            Space_Full,
  output logic                            Underflow
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t              r_state, w_state_next;
  logic [OW-1:0]       r_owner, w_owner_next;
  logic [OW-1:0]       r_last_owner, w_last_next;
  logic [BW-1:0]       r_beat, w_beat_next;
  logic [CW-1:0]       r_count, w_count_next;
  logic                r_we;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                r_underflow;

  logic                  w_grant_en;
  logic                  w_accept;
  logic                  w_read;
  logic [OW-1:0]         w_pick;
  logic [DATA_WIDTH-1:0] w_words [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
    assign w_words[gi] = Req_Data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // First requester found scanning circularly, starting just after last.
  function automatic logic [OW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                            input logic [OW-1:0] last);
    logic [OW-1:0] pick;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = OW'(idx);
      end
    end
    return pick;
  endfunction

  assign w_pick     = rr_pick(Req, r_last_owner);
  assign w_grant_en = (r_state == BURST) && Enable && (r_count != FULL_CNT);
  assign Grant      = w_grant_en ? (NUM_REQ'(1) << r_owner) : '0;
  assign w_accept   = w_grant_en && Req[r_owner];
  // A read frees space only from the next cycle on: Grant already used r_count.
  assign w_read     = RE_Mon && (r_count != '0);
  assign w_count_next = r_count + CW'(w_accept) - CW'(w_read);

  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_last_next  = r_last_owner;
    w_beat_next  = r_beat;
    case (r_state)
      IDLE: begin
        if (Enable && (|Req)) begin
          w_owner_next = w_pick;
          w_last_next  = w_pick;
          w_beat_next  = '0;
          w_state_next = BURST;
        end
      end
      BURST: begin
        if (w_accept) begin
          w_beat_next = (r_beat == LAST_BEAT) ? '0 : r_beat + 1'b1;
        end
        if (!Enable || !Req[r_owner] || (w_accept && (r_beat == LAST_BEAT))) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_last_owner <= OW'(NUM_REQ - 1);
      r_beat       <= '0;
      r_count      <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_underflow  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_owner      <= w_owner_next;
      r_last_owner <= w_last_next;
      r_beat       <= w_beat_next;
      r_count      <= w_count_next;
      r_we         <= w_accept;
      if (w_accept) begin
        r_wdata <= w_words[r_owner];
      end
      if (RE_Mon && (r_count == '0)) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign WE         = r_we;
  assign Write_Data = r_wdata;
  assign Count      = r_count;
  assign Space_Full = (r_count == FULL_CNT);
  assign Underflow  = r_underflow;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: a vector table for the single-producer
// case plus hand-written sequences for round-robin, full, underflow and reset.
module tb_fifo_write_arbiter;

  logic        Clock;
  logic        Reset;
  logic        Enable;
  logic [3:0]  Req;
  logic [63:0] Req_Data;
  logic [3:0]  Grant;
  logic        RE_Mon;
  logic        WE;
  logic [15:0] Write_Data;
  logic [5:0]  Count;
  logic        Space_Full;
  logic        Underflow;

  int checks;
  int failures;

  fifo_write_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(16), .DEPTH(32), .MAX_BURST(4)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Req(Req),
    .Req_Data(Req_Data), .Grant(Grant), .RE_Mon(RE_Mon), .WE(WE),
    .Write_Data(Write_Data), .Count(Count), .Space_Full(Space_Full),
    .Underflow(Underflow)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        en;
    logic [3:0]  req;
    logic        re;
    logic [15:0] d0;
    logic [3:0]  grant;
    logic        we;
    logic [15:0] wd;
    logic [5:0]  cnt;
  } vec_t;

  vec_t        tbl [9];
  logic [15:0] words [4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic apply_reset();
    Reset  = 1'b0;
    Enable = 1'b0;
    Req    = 4'b0000;
    RE_Mon = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int we_cnt;
    int o;
    checks   = 0;
    failures = 0;
    words[0] = 16'hA000; words[1] = 16'hB111;
    words[2] = 16'hC222; words[3] = 16'hD333;

    //         en   req     re    d0        grant   we    wd        cnt
    tbl[0] = '{1'b1, 4'b0001, 1'b0, 16'h0100, 4'b0000, 1'b0, 16'h0000, 6'd0};
    tbl[1] = '{1'b1, 4'b0001, 1'b0, 16'h0100, 4'b0001, 1'b1, 16'h0100, 6'd1};
    tbl[2] = '{1'b1, 4'b0001, 1'b0, 16'h1050, 4'b0001, 1'b1, 16'h1050, 6'd2};
    tbl[3] = '{1'b1, 4'b0001, 1'b0, 16'h2000, 4'b0001, 1'b1, 16'h2000, 6'd3};
    tbl[4] = '{1'b1, 4'b0001, 1'b0, 16'h4800, 4'b0001, 1'b1, 16'h4800, 6'd4};
    tbl[5] = '{1'b1, 4'b0001, 1'b0, 16'h0070, 4'b0000, 1'b0, 16'h4800, 6'd4};
    tbl[6] = '{1'b1, 4'b0001, 1'b0, 16'h0070, 4'b0001, 1'b1, 16'h0070, 6'd5};
    tbl[7] = '{1'b1, 4'b0000, 1'b0, 16'h0070, 4'b0001, 1'b0, 16'h0070, 6'd5};
    tbl[8] = '{1'b1, 4'b0000, 1'b0, 16'h0070, 4'b0000, 1'b0, 16'h0070, 6'd5};

    Reset    = 1'b1;
    Enable   = 1'b0;
    Req      = 4'b0000;
    RE_Mon   = 1'b0;
    Req_Data = '0;
    #2 Reset = 1'b0;
    #4;
    chk("rst_we", WE, 1'b0);
    chk("rst_wdata", Write_Data, 16'h0000);
    chk("rst_grant", Grant, 4'b0000);
    chk("rst_count", Count, 6'd0);
    chk("rst_underflow", Underflow, 1'b0);
    chk("rst_full", Space_Full, 1'b0);
    cyc();
    Reset = 1'b1;

    // single producer via table
    for (int i = 0; i < 9; i++) begin
      Enable   = tbl[i].en;
      Req      = tbl[i].req;
      RE_Mon   = tbl[i].re;
      Req_Data = {48'h0, tbl[i].d0};
      #1;
      chk($sformatf("single_grant[%0d]", i), Grant, tbl[i].grant);
      cyc();
      chk($sformatf("single_we[%0d]", i), WE, tbl[i].we);
      chk($sformatf("single_wd[%0d]", i), Write_Data, tbl[i].wd);
      chk($sformatf("single_cnt[%0d]", i), Count, tbl[i].cnt);
    end

    // round robin, all requesting
    apply_reset();
    Req_Data = {words[3], words[2], words[1], words[0]};
    Enable   = 1'b1;
    Req      = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      o = b % 4;
      #1;
      chk($sformatf("rr_idle_grant[%0d]", b), Grant, 4'b0000);
      cyc();
      chk($sformatf("rr_gap_we[%0d]", b), WE, 1'b0);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("rr_grant[%0d.%0d]", b, k), Grant, 4'b0001 << o);
        cyc();
        chk($sformatf("rr_we[%0d.%0d]", b, k), WE, 1'b1);
        chk($sformatf("rr_wd[%0d.%0d]", b, k), Write_Data, words[o]);
      end
    end
    chk("rr_count", Count, 6'd20);

    // fill to DEPTH with producer 1, no reads
    apply_reset();
    Enable = 1'b1;
    Req    = 4'b0010;
    we_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      cyc();
      if (WE) we_cnt++;
    end
    chk("full_we_pulses", we_cnt, 32);
    chk("full_count", Count, 6'd32);
    chk("full_flag", Space_Full, 1'b1);
    cyc();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("full_grant[%0d]", c), Grant, 4'b0000);
      cyc();
      chk($sformatf("full_we[%0d]", c), WE, 1'b0);
      chk($sformatf("full_hold_cnt[%0d]", c), Count, 6'd32);
    end
    RE_Mon = 1'b1;
    #1;
    chk("full_read_grant", Grant, 4'b0000);
    cyc();
    RE_Mon = 1'b0;
    chk("full_read_cnt", Count, 6'd31);
    chk("full_read_flag", Space_Full, 1'b0);
    chk("full_read_we", WE, 1'b0);
    #1;
    chk("full_resume_grant", Grant, 4'b0010);
    cyc();
    chk("full_resume_we", WE, 1'b1);
    chk("full_resume_wd", Write_Data, words[1]);
    chk("full_again_cnt", Count, 6'd32);
    chk("full_again_flag", Space_Full, 1'b1);
    #1;
    chk("full_again_grant", Grant, 4'b0000);

    // simultaneous accept and read, then drain and underflow
    apply_reset();
    Enable = 1'b1;
    Req    = 4'b0001;
    repeat (13) cyc();
    chk("sim_pre_cnt", Count, 6'd10);
    RE_Mon = 1'b1;
    #1;
    chk("sim_grant", Grant, 4'b0001);
    cyc();
    chk("sim_cnt", Count, 6'd10);
    chk("sim_we", WE, 1'b1);
    Req = 4'b0000;
    repeat (10) cyc();
    chk("drain_cnt", Count, 6'd0);
    chk("drain_underflow", Underflow, 1'b0);
    cyc();
    RE_Mon = 1'b0;
    chk("uf_flag", Underflow, 1'b1);
    chk("uf_cnt", Count, 6'd0);
    cyc();
    chk("uf_sticky", Underflow, 1'b1);

    // asynchronous reset in the middle of a burst
    Req = 4'b0001;
    cyc();
    cyc();
    chk("mid_we_before", WE, 1'b1);
    #2 Reset = 1'b0;
    #2;
    chk("mid_we", WE, 1'b0);
    chk("mid_wd", Write_Data, 16'h0000);
    chk("mid_cnt", Count, 6'd0);
    chk("mid_underflow", Underflow, 1'b0);
    chk("mid_grant", Grant, 4'b0000);
    chk("mid_full", Space_Full, 1'b0);
    #1 Reset = 1'b1;
    Req = 4'b1111;
    cyc();
    chk("mid_first_grant", Grant, 4'b0001);
    cyc();
    chk("mid_first_wd", Write_Data, words[0]);

    // Enable drop, then owner Req drop
    apply_reset();
    Enable = 1'b1;
    Req    = 4'b0001;
    cyc();
    cyc();
    Enable = 1'b0;
    #1;
    chk("en_drop_grant", Grant, 4'b0000);
    cyc();
    chk("en_drop_we", WE, 1'b0);
    chk("en_drop_cnt", Count, 6'd1);
    Enable = 1'b1;
    Req    = 4'b0101;
    #1;
    chk("en_idle_grant", Grant, 4'b0000);
    cyc();
    chk("rq_owner2_grant", Grant, 4'b0100);
    cyc();
    chk("rq_beat1_wd", Write_Data, words[2]);
    cyc();
    chk("rq_beat2_cnt", Count, 6'd3);
    Req = 4'b0001;
    #1;
    chk("rq_drop_grant", Grant, 4'b0100);
    cyc();
    chk("rq_drop_we", WE, 1'b0);
    chk("rq_drop_cnt", Count, 6'd3);
    chk("rq_idle_grant", Grant, 4'b0000);
    cyc();
    chk("rq_next_grant", Grant, 4'b0001);
    cyc();
    chk("rq_next_wd", Write_Data, words[0]);
    chk("rq_next_cnt", Count, 6'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
